// File: rtl/l0_pkg.sv
// Shared layer-0 definitions: feature-map geometry, datapath widths and the
// pooling scheduler state encoding.
package l0_pkg;

    localparam int FM_W   = 26;
    localparam int POOL_W = 13;
    localparam int AW     = 10;
    localparam int DW     = 18;
    localparam int IW     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/l0_max2.sv
// Registered unsigned running maximum for one channel of a 2x2 pooling
// window. clr wins over ld, and ld wins over upd.
module l0_max2
    import l0_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld,
    input  logic          upd,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= din;
        end else if (upd && (din > q)) begin
            q <= din;
        end
    end

endmodule

// File: rtl/l0_pool_sched.sv
// Layer-0 2x2 max-pool scheduler: walks the 13x13 window grid, reads four
// words per window from both channel RAMs and presents the pooled pair.
//
// state | meaning
// IDLE  | waiting for strt
// RD    | issuing the four window reads, sub selects the offset
// WAIT  | last read word returning from RAM
// OUT   | pooled pair presented, held until out_rdy
module l0_pool_sched
    import l0_pkg::*;
#(
    parameter int FM_W   = l0_pkg::FM_W,
    parameter int POOL_W = l0_pkg::POOL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          strt,
    input  logic          tx_done,
    output logic [AW-1:0] addr_rd,
    input  logic [DW-1:0] din_0,
    input  logic [DW-1:0] din_1,
    input  logic          out_rdy,
    output logic          out_vld,
    output logic [DW-1:0] dout_0,
    output logic [DW-1:0] dout_1,
    output logic [IW-1:0] out_idx,
    output logic          bsy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [1:0]    sub_q, sub_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic          cap_q, cap_first_q;
    logic          last_win;
    logic [AW-1:0] win_base;
    logic [AW-1:0] win_off;
    logic [IW-1:0] win_idx;
    logic [DW-1:0] max_0, max_1;

    assign last_win = (row_q == 4'(POOL_W - 1)) && (col_q == 4'(POOL_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sub_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        row_d   = row_q;
        col_d   = col_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (strt) begin
                    state_d = RD;
                    sub_d   = 2'd0;
                end
            end
            RD: begin
                sub_d = sub_q + 2'd1;
                if (sub_q == 2'd3) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_rdy) begin
                    if (last_win) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        state_d = RD;
                        sub_d   = 2'd0;
                        if (col_q == 4'(POOL_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including the final-window done pulse.
        if (tx_done) begin
            state_d = IDLE;
            sub_d   = '0;
            row_d   = '0;
            col_d   = '0;
            done    = 1'b0;
        end
    end

    always_comb begin
        win_off = '0;
        case (sub_q)
            2'd0:    win_off = '0;
            2'd1:    win_off = AW'(1);
            2'd2:    win_off = AW'(FM_W);
            default: win_off = AW'(FM_W + 1);
        endcase
    end

    assign win_base = ({6'd0, row_q} * AW'(2 * FM_W)) + {5'd0, col_q, 1'b0};
    assign addr_rd  = (state_q == RD) ? (win_base + win_off) : '0;
    assign win_idx  = (IW'(row_q) * IW'(POOL_W)) + IW'(col_q);

    // RAM data lags the address by one cycle, so the load/update strobes do too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q       <= 1'b0;
            cap_first_q <= 1'b0;
        end else if (tx_done) begin
            cap_q       <= 1'b0;
            cap_first_q <= 1'b0;
        end else begin
            cap_q       <= (state_q == RD);
            cap_first_q <= (state_q == RD) && (sub_q == 2'd0);
        end
    end

    l0_max2 u_max_0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tx_done),
        .ld    (cap_q && cap_first_q),
        .upd   (cap_q && !cap_first_q),
        .din   (din_0),
        .q     (max_0)
    );

    l0_max2 u_max_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tx_done),
        .ld    (cap_q && cap_first_q),
        .upd   (cap_q && !cap_first_q),
        .din   (din_1),
        .q     (max_1)
    );

    assign out_vld = (state_q == OUT);
    assign bsy     = (state_q != IDLE);
    assign dout_0  = out_vld ? max_0 : '0;
    assign dout_1  = out_vld ? max_1 : '0;
    assign out_idx = out_vld ? win_idx : '0;

endmodule

// File: tb/tb_l0_pool_sched.sv
// Scoreboard bench for l0_pool_sched: RAM model ch0[a]=a, ch1[a]=675-a,
// expected pooled pairs queued at strt and popped on each accepted output.
module tb_l0_pool_sched;
    import l0_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          strt = 1'b0;
    logic          tx_done = 1'b0;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] din_0 = '0;
    logic [DW-1:0] din_1 = '0;
    logic [AW-1:0] addr_rd;
    logic          out_vld;
    logic [DW-1:0] dout_0, dout_1;
    logic [IW-1:0] out_idx;
    logic          bsy, done;

    typedef struct {
        int idx;
        int d0;
        int d1;
    } exp_t;

    exp_t exp_q[$];
    exp_t acc_log[$];
    exp_t mon_e;
    int   addr_log[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   rd_left = 0;

    l0_pool_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .strt    (strt),
        .tx_done (tx_done),
        .addr_rd (addr_rd),
        .din_0   (din_0),
        .din_1   (din_1),
        .out_rdy (out_rdy),
        .out_vld (out_vld),
        .dout_0  (dout_0),
        .dout_1  (dout_1),
        .out_idx (out_idx),
        .bsy     (bsy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        din_0 <= DW'(addr_rd);
        din_1 <= DW'(675 - int'(addr_rd));
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rd_left > 0) begin
            addr_log.push_back(int'(addr_rd));
            rd_left--;
        end
        if (tx_done || !rst_n) rd_left = 0;
        else if ((strt && !bsy) || (out_vld && out_rdy && !done)) rd_left = 4;
        if (int'(addr_rd) > 675) check("addr_range", int'(addr_rd), 675);
        if (!out_vld)
            check("zero_when_invalid", int'(dout_0) + int'(dout_1) + int'(out_idx), 0);
        if (done) begin
            done_cnt++;
            check("done_handshake", int'(out_vld && out_rdy), 1);
            check("done_idx", int'(out_idx), 168);
        end
        if (out_vld && out_rdy) begin
            acc_log.push_back('{int'(out_idx), int'(dout_0), int'(dout_1)});
            if (exp_q.size() == 0) begin
                check("unexpected_output", int'(out_idx), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_idx", int'(out_idx), mon_e.idx);
                check("dout_0", int'(dout_0), mon_e.d0);
                check("dout_1", int'(dout_1), mon_e.d1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue_pass();
        for (int i = 0; i < 169; i++) begin
            int r, c, b;
            r = i / 13;
            c = i % 13;
            b = 52 * r + 2 * c;
            exp_q.push_back('{i, b + 27, 675 - b});
        end
        @(negedge clk) strt = 1'b1;
        @(negedge clk) strt = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bsy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < 3000), 1);
    endtask

    task automatic wait_addr(input int a, input string name);
        int n = 0;
        @(negedge clk);
        while (int'(addr_rd) != a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(addr_rd), a);
    endtask

    task automatic wait_vld(input string name);
        int n = 0;
        while (!out_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(out_vld), 1);
    endtask

    initial begin
        int lb, ab, db;
        int v_d0, v_d1, v_idx;

        tick(2);
        #1;
        check("rst_addr", int'(addr_rd), 0);
        check("rst_vld", int'(out_vld), 0);
        check("rst_bsy", int'(bsy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk) rst_n = 1'b1;
        tick(2);
        check("idle_bsy", int'(bsy), 0);

        // Full pass, with a stray strt while busy that must be ignored.
        lb = addr_log.size();
        ab = acc_log.size();
        db = done_cnt;
        issue_pass();
        tick(20);
        check("busy_mid_pass", int'(bsy), 1);
        @(negedge clk) strt = 1'b1;
        @(negedge clk) strt = 1'b0;
        wait_idle("pass_a_timeout");
        check("pass_a_count", acc_log.size() - ab, 169);
        check("pass_a_done", done_cnt - db, 1);
        check("first_idx", acc_log[ab].idx, 0);
        check("first_d0", acc_log[ab].d0, 27);
        check("first_d1", acc_log[ab].d1, 675);
        check("last_idx", acc_log[ab + 168].idx, 168);
        check("last_d0", acc_log[ab + 168].d0, 675);
        check("last_d1", acc_log[ab + 168].d1, 27);
        check("addr_count", addr_log.size() - lb, 676);
        check("w0_a0", addr_log[lb + 0], 0);
        check("w0_a1", addr_log[lb + 1], 1);
        check("w0_a2", addr_log[lb + 2], 26);
        check("w0_a3", addr_log[lb + 3], 27);
        check("w1_a0", addr_log[lb + 4], 2);
        check("w1_a1", addr_log[lb + 5], 3);
        check("w1_a2", addr_log[lb + 6], 28);
        check("w1_a3", addr_log[lb + 7], 29);
        check("w13_a0", addr_log[lb + 52], 52);
        check("w13_a1", addr_log[lb + 53], 53);
        check("w13_a2", addr_log[lb + 54], 78);
        check("w13_a3", addr_log[lb + 55], 79);
        check("w168_a0", addr_log[lb + 672], 648);
        check("w168_a1", addr_log[lb + 673], 649);
        check("w168_a2", addr_log[lb + 674], 674);
        check("w168_a3", addr_log[lb + 675], 675);

        // Backpressure at idx 5, then abort during the reads of idx 40.
        ab = acc_log.size();
        db = done_cnt;
        issue_pass();
        wait_addr(10, "reach_w5");
        out_rdy = 1'b0;
        wait_vld("w5_vld");
        v_d0 = int'(dout_0);
        v_d1 = int'(dout_1);
        v_idx = int'(out_idx);
        check("stall_idx", v_idx, 5);
        check("stall_d0", v_d0, 37);
        check("stall_d1", v_d1, 665);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_vld", int'(out_vld), 1);
            check("stall_hold_d0", int'(dout_0), v_d0);
            check("stall_hold_d1", int'(dout_1), v_d1);
            check("stall_hold_idx", int'(out_idx), v_idx);
            check("stall_addr", int'(addr_rd), 0);
        end
        out_rdy = 1'b1;
        wait_addr(158, "reach_w40");
        tx_done = 1'b1;
        @(negedge clk) tx_done = 1'b0;
        check("abort_bsy", int'(bsy), 0);
        check("abort_vld", int'(out_vld), 0);
        check("abort_addr", int'(addr_rd), 0);
        tick(3);
        check("abort_no_done", done_cnt - db, 0);
        check("abort_count", acc_log.size() - ab, 40);
        exp_q.delete();

        // Restart after abort begins again at window 0, address 0.
        lb = addr_log.size();
        ab = acc_log.size();
        db = done_cnt;
        issue_pass();
        wait_idle("pass_c_timeout");
        check("restart_addr0", addr_log[lb], 0);
        check("restart_idx0", acc_log[ab].idx, 0);
        check("pass_c_count", acc_log.size() - ab, 169);
        check("pass_c_done", done_cnt - db, 1);

        // Asynchronous reset while holding an output.
        out_rdy = 1'b0;
        issue_pass();
        wait_vld("pass_d_vld");
        #3 rst_n = 1'b0;
        #1;
        check("arst_vld", int'(out_vld), 0);
        check("arst_d0", int'(dout_0), 0);
        check("arst_d1", int'(dout_1), 0);
        check("arst_idx", int'(out_idx), 0);
        check("arst_bsy", int'(bsy), 0);
        check("arst_addr", int'(addr_rd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        exp_q.delete();
        tick(5);
        check("post_rst_bsy", int'(bsy), 0);
        check("post_rst_vld", int'(out_vld), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l0_pool_sched.md
L0_POOL_SCHED -- requirements
Module: l0_pool_sched

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 strt  input  1  pulse; layer-0 feature maps are complete, begin pooling pass.
REQ-004 tx_done  input  1  synchronous abort; clears the pass and returns to IDLE.
REQ-005 addr_rd  output  10  read address to both layer-0 RAMs (shared).
REQ-006 din_0, din_1  input  18 each  layer-0 RAM read data, channels 0/1, valid one cycle after addr_rd.
REQ-007 out_rdy  input  1  downstream accepts the current pooled pair.
REQ-008 out_vld  output  1  dout_0/dout_1/out_idx valid.
REQ-009 dout_0, dout_1  output  18 each  2x2 max-pooled value, channels 0/1.
REQ-010 out_idx  output  8  pooled index, row*13+col, 0..168.
REQ-011 bsy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the last pooled pair is accepted.
REQ-013 Parameters: FM_W default 26 (feature-map width and height); POOL_W default 13 (FM_W/2).

Function
REQ-014 States: IDLE, RD, WAIT, OUT. State and sub-counter (2 bit) and window counters row/col (4 bit each) are registered.
REQ-015 IDLE: strt=1 -> RD with sub=0. strt is ignored in every other state.
REQ-016 Window base address = 2*row*FM_W + 2*col. Offsets by sub: 0 -> 0, 1 -> 1, 2 -> FM_W, 3 -> FM_W+1.
REQ-017 RD: addr_rd = base + offset(sub). sub increments each cycle. sub=3 -> WAIT.
REQ-018 addr_rd = 0 in IDLE, WAIT and OUT.
REQ-019 Data returned one cycle after each RD address: the first returned word (sub=0) loads the max registers; each later word updates max_x <= (din_x > max_x) ? din_x : max_x. Comparison is unsigned 18-bit, because inputs are post-ReLU and never negative.
REQ-020 WAIT: captures the 4th word -> OUT. out_vld rises in the 6th cycle after the edge that sampled strt (4 RD cycles + 1 WAIT cycle).
REQ-021 OUT: out_vld=1. dout_x = max_x. out_idx = row*POOL_W+col. All three are held stable until out_rdy=1.
REQ-022 OUT with out_rdy=1, window not last: col+1 -> RD, sub=0. At col=POOL_W-1: col=0, row+1.
REQ-023 OUT with out_rdy=1, last window (row=col=POOL_W-1): done=1 for that cycle -> IDLE; row and col clear to 0.
REQ-024 tx_done=1 in any state overrides all other transitions: next state IDLE; row, col, sub and max registers clear; out_vld=0 next cycle; done does not pulse.
REQ-025 No addr_rd value exceeds FM_W*FM_W-1 (675) during a pass.
REQ-026 dout_x and out_idx read 0 whenever out_vld=0 (registered outputs cleared on leaving OUT).

Reset
REQ-027 rst_n low: state=IDLE; row, col, sub = 0; max_0, max_1 = 0; addr_rd, out_vld, dout_0, dout_1, out_idx, done, bsy = 0, all asynchronously.
REQ-028 Reset asserted mid-pass abandons the pass. After release the block waits in IDLE for a new strt.

Structure
REQ-029 Package l0_pkg holds FM_W, POOL_W and the state enum typedef (IDLE, RD, WAIT, OUT), shared with layer-0 logic.
REQ-030 One sub-module, l0_max2 (18-bit unsigned registered max with load/update/clear), instanced once per channel. All other logic stays in l0_pool_sched.

Verification
REQ-031 RAM model with ch0[a]=a and ch1[a]=675-a, out_rdy=1, strt pulse -> 169 outputs in raster order; first output dout_0=27, dout_1=675, idx=0; last output dout_0=675, dout_1=27, idx=168; done pulses once.
REQ-032 Address trace: first window reads 0,1,26,27; second window 2,3,28,29; window idx 13 reads 52,53,78,79; last window reads 648,649,674,675.
REQ-033 out_rdy held low 10 cycles at idx 5 -> out_vld, dout and idx stay constant; no addr_rd activity; resume on out_rdy=1.
REQ-034 tx_done asserted during RD of idx 40 -> IDLE next cycle, out_vld=0, no done pulse; a new strt restarts at idx 0, address 0.
REQ-035 strt re-pulsed while bsy=1 -> ignored; sequence and output count are unchanged.
REQ-036 rst_n low in OUT -> all outputs 0 immediately, without waiting for a clock edge; with strt held low after release, the block stays in IDLE.
